cmd_responder: RTL



---
 rtl/cmd_responder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cmd_responder.sv
// Command-bus endpoint: 4-deep input FIFO, local register bank, trigger pulse and completion tracking.
// Define CMD_RESP_BYPASS_EN to forward words addressed to other module IDs instead of discarding them.
module cmd_responder #(
  parameter logic [6:0] MDID = 7'd1,
  parameter int         NREG = 8
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        cmd_in_wr,
  input  logic [63:0] cmd_in,
  output logic        cmd_in_alf,
  output logic        cmd_out_wr,
  output logic [63:0] cmd_out,
  input  logic        cmd_out_alf,
  output logic        trig_start,
  input  logic        trig_done
);
  localparam int          AW     = $clog2(NREG);
  localparam logic [19:0] NREG_A = 20'(NREG);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;
  state_t state, state_nxt;

  logic [63:0] fifo_mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count, count_nxt;
  logic        push, pop, fifo_full, fifo_empty;

  logic        busy, done, ovf;
  logic [15:0] done_cnt;
  logic [31:0] scr [NREG];

  logic [63:0] head;
  logic [19:0] head_addr;
  logic [AW-1:0] head_idx;
  logic        head_wr, foreign, in_range, acc_ok, send, send_foreign;
  logic [31:0] rd_data, status_word;
  logic [63:0] resp;

  logic          scr_we_p1, clr_done_p1, clr_ovf_p1;
  logic [AW-1:0] scr_idx_p1;
  logic [31:0]   scr_data_p1;

  assign fifo_full  = (count == 3'd4);
  assign fifo_empty = (count == 3'd0);
  assign push       = cmd_in_wr && !fifo_full;
  assign count_nxt  = count + {2'b00, push} - {2'b00, pop};

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (!fifo_empty && !cmd_out_alf) begin
        pop       = 1'b1;
        state_nxt = EXEC;
      end
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      cmd_in_alf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count      <= count_nxt;
      cmd_in_alf <= (count_nxt >= 3'd2);
    end
  end

  // p0: decode the FIFO head while it is being popped
  assign head        = fifo_mem[rd_ptr];
  assign head_addr   = head[51:32];
  assign head_idx    = head[32 +: AW];
  assign head_wr     = head[59];
  assign foreign     = (head[58:52] != MDID);
  assign in_range    = (head_addr < NREG_A);
  assign acc_ok      = (head[63:61] == 3'b100) && in_range && !(head_wr && head_addr == 20'd1);
  assign status_word = {done_cnt, 13'b0, ovf, done, busy};

`ifdef CMD_RESP_BYPASS_EN
  assign send_foreign = 1'b1;
`else
  assign send_foreign = 1'b0;
`endif
  assign send = foreign ? send_foreign : 1'b1;

  always_comb begin
    rd_data = '0;
    if (head_addr == 20'd1)                 rd_data = status_word;
    else if (head_addr >= 20'd2 && in_range) rd_data = scr[head_idx];
  end

  assign resp = foreign ? head
                        : {head[63:61], acc_ok, head[59:32], (acc_ok && !head_wr) ? rd_data : head[31:0]};

  // p1: response and side-effect flags, all live during the EXEC cycle
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cmd_out_wr  <= 1'b0;
      cmd_out     <= '0;
      trig_start  <= 1'b0;
      scr_we_p1   <= 1'b0;
      clr_done_p1 <= 1'b0;
      clr_ovf_p1  <= 1'b0;
    end else begin
      cmd_out_wr  <= pop && send;
      trig_start  <= pop && !foreign && acc_ok && head_wr && head_addr == 20'd0 && head[0];
      scr_we_p1   <= pop && !foreign && acc_ok && head_wr && head_addr >= 20'd2;
      clr_done_p1 <= pop && !foreign && acc_ok && !head_wr && head_addr == 20'd1 && done;
      clr_ovf_p1  <= pop && !foreign && acc_ok && !head_wr && head_addr == 20'd1 && ovf;
      if (pop && send) cmd_out <= resp;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      scr_idx_p1  <= head_idx;
      scr_data_p1 <= head[31:0];
    end
  end

  // Clear-on-read only drops bits the read actually reported, so a done arriving meanwhile survives
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      done_cnt <= '0;
      for (int i = 0; i < NREG; i++) scr[i] <= '0;
    end else begin
      busy     <= trig_start | (busy & ~trig_done);
      done     <= trig_done | (done & ~clr_done_p1);
      ovf      <= (cmd_in_wr && fifo_full) | (ovf & ~clr_ovf_p1);
      done_cnt <= done_cnt + {15'd0, trig_done};
      if (scr_we_p1) scr[scr_idx_p1] <= scr_data_p1;
    end
  end
endmodule
